// File: rtl/ccu_pkg.sv
// Shared definitions for the CCU snoop dispatcher: CR response bit positions,
// FSM state encoding and the forwarder-selection helper.
package ccu_pkg;

  localparam int unsigned CR_W      = 5;
  localparam int unsigned CR_DT     = 0;
  localparam int unsigned CR_ERR    = 1;
  localparam int unsigned CR_PD     = 2;
  localparam int unsigned CR_IS     = 3;
  localparam int unsigned CR_WU     = 4;
  localparam int unsigned MAX_PORTS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AC,
    ST_CR,
    ST_CD,
    ST_RESP
  } state_e;

  function automatic int unsigned lowest_set_idx(input logic [MAX_PORTS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = MAX_PORTS; i > 0; i--) begin
      if (v[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ccu_cd_drain.sv
// Per-port CD beat counter: counts handshakes while enabled and flags completion
// after Beats transfers; fin_o also covers the completing handshake itself.
module ccu_cd_drain #(
  parameter int unsigned Beats = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic hs_i,
  output logic done_o,
  output logic fin_o
);

  localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            step;
  logic            last_hs;

  always_comb begin
    step    = en_i & hs_i & ~done_q;
    last_hs = step & (cnt_q == CntW'(Beats - 1));
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (step) begin
      if (last_hs) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign fin_o  = done_q | last_hs;

endmodule

// File: rtl/ccu_snoop_dispatch.sv
// Coherent snoop engine: broadcasts AC to a masked target set, merges CR flags,
// forwards one line of CD from the lowest data-carrying responder and drains the rest.
module ccu_snoop_dispatch
  import ccu_pkg::*;
#(
  parameter int unsigned NoPorts   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 512,
  parameter int unsigned IdxWidth  = $clog2(NoPorts)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [3:0]                   req_snoop_i,
  input  logic [2:0]                   req_prot_i,
  input  logic [IdxWidth-1:0]          req_init_i,
  input  logic [NoPorts-1:0]           req_mask_i,
  output logic [NoPorts-1:0]           ac_valid_o,
  input  logic [NoPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]         ac_addr_o,
  output logic [3:0]                   ac_snoop_o,
  output logic [2:0]                   ac_prot_o,
  input  logic [NoPorts-1:0]           cr_valid_i,
  output logic [NoPorts-1:0]           cr_ready_o,
  input  logic [NoPorts*5-1:0]         cr_resp_i,
  input  logic [NoPorts-1:0]           cd_valid_i,
  output logic [NoPorts-1:0]           cd_ready_o,
  input  logic [NoPorts*DataWidth-1:0] cd_data_i,
  input  logic [NoPorts-1:0]           cd_last_i,
  output logic                         d_valid_o,
  input  logic                         d_ready_i,
  output logic [DataWidth-1:0]         d_data_o,
  output logic                         d_last_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         res_data_o,
  output logic                         res_dirty_o,
  output logic                         res_shared_o,
  output logic                         res_err_o,
  output logic                         busy_o
);

  localparam int unsigned Beats = LineWidth / DataWidth;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [3:0]             snoop_q, snoop_d;
  logic [2:0]             prot_q, prot_d;
  logic [NoPorts-1:0]     target_q, target_d;
  logic [NoPorts-1:0]     ac_done_q, ac_done_d;
  logic [NoPorts-1:0]     cr_done_q, cr_done_d;
  logic [NoPorts-1:0]     dt_q, dt_d;
  logic [IdxWidth-1:0]    fwd_q, fwd_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   dirty_q, dirty_d;
  logic                   shared_q, shared_d;
  logic                   err_q, err_d;
  logic                   data_q, data_d;

  logic [NoPorts-1:0]     ac_hs, cr_hs;
  logic [NoPorts-1:0]     drain_done, drain_fin;
  logic                   fwd_last;
  logic [NoPorts-1:0]     unused_wu;

  for (genvar g = 0; g < NoPorts; g++) begin : g_drain
    ccu_cd_drain #(.Beats(Beats)) u_drain (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (state_q != ST_CD),
      .en_i   (dt_q[g] & (state_q == ST_CD)),
      .hs_i   (cd_valid_i[g] & cd_ready_o[g]),
      .done_o (drain_done[g]),
      .fin_o  (drain_fin[g])
    );
  end

  // CD steering kept apart from the FSM so the drain feedback has no combinational cycle.
  always_comb begin
    cd_ready_o = '0;
    d_valid_o  = 1'b0;
    d_data_o   = '0;
    d_last_o   = 1'b0;
    fwd_last   = 1'b0;
    if (state_q == ST_CD) begin
      d_last_o = (cnt_q == CntW'(Beats - 1));
      for (int unsigned i = 0; i < NoPorts; i++) begin
        if (dt_q[i]) begin
          if (IdxWidth'(i) == fwd_q) begin
            d_valid_o     = cd_valid_i[i] & ~drain_done[i];
            d_data_o      = cd_data_i[i*DataWidth +: DataWidth];
            cd_ready_o[i] = d_ready_i & ~drain_done[i];
            fwd_last      = cd_last_i[i];
          end else begin
            cd_ready_o[i] = ~drain_done[i];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NoPorts; i++) unused_wu[i] = cr_resp_i[i*CR_W + CR_WU];
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    prot_d      = prot_q;
    target_d    = target_q;
    ac_done_d   = ac_done_q;
    cr_done_d   = cr_done_q;
    dt_d        = dt_q;
    fwd_d       = fwd_q;
    cnt_d       = cnt_q;
    dirty_d     = dirty_q;
    shared_d    = shared_q;
    err_d       = err_q;
    data_d      = data_q;
    req_ready_o = 1'b0;
    ac_valid_o  = '0;
    cr_ready_o  = '0;
    res_valid_o = 1'b0;
    ac_hs       = '0;
    cr_hs       = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          snoop_d  = req_snoop_i;
          prot_d   = req_prot_i;
          target_d = req_mask_i & ~(NoPorts'(1) << req_init_i);
          state_d  = (target_d == '0) ? ST_RESP : ST_AC;
        end
      end

      ST_AC, ST_CR: begin
        if (state_q == ST_AC) begin
          ac_valid_o = target_q & ~ac_done_q;
          ac_hs      = ac_valid_o & ac_ready_i;
          ac_done_d  = ac_done_q | ac_hs;
        end
        // CR is taken from a port as soon as its AC has been (or is being) accepted.
        cr_ready_o = target_q & ~cr_done_q & ac_done_d;
        cr_hs      = cr_ready_o & cr_valid_i;
        cr_done_d  = cr_done_q | cr_hs;
        for (int unsigned i = 0; i < NoPorts; i++) begin
          if (cr_hs[i]) begin
            dirty_d  = dirty_d  | cr_resp_i[i*CR_W + CR_PD];
            shared_d = shared_d | cr_resp_i[i*CR_W + CR_IS];
            err_d    = err_d    | cr_resp_i[i*CR_W + CR_ERR];
            dt_d[i]  = cr_resp_i[i*CR_W + CR_DT] & ~cr_resp_i[i*CR_W + CR_ERR];
          end
        end
        if (state_q == ST_AC) begin
          if ((target_q & ~ac_done_d) == '0) state_d = ST_CR;
        end else if ((target_q & ~cr_done_d) == '0) begin
          if (dt_d == '0) begin
            state_d = ST_RESP;
          end else begin
            fwd_d   = IdxWidth'(lowest_set_idx(MAX_PORTS'(dt_d)));
            state_d = ST_CD;
          end
        end
      end

      ST_CD: begin
        if (d_valid_o & d_ready_i) begin
          cnt_d = d_last_o ? '0 : cnt_q + 1'b1;
          if (fwd_last != d_last_o) err_d = 1'b1;
        end
        if ((dt_q & ~drain_fin) == '0) begin
          data_d  = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_d   = ST_IDLE;
          target_d  = '0;
          ac_done_d = '0;
          cr_done_d = '0;
          dt_d      = '0;
          fwd_d     = '0;
          cnt_d     = '0;
          dirty_d   = 1'b0;
          shared_d  = 1'b0;
          err_d     = 1'b0;
          data_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      target_q  <= '0;
      ac_done_q <= '0;
      cr_done_q <= '0;
      dt_q      <= '0;
      fwd_q     <= '0;
      cnt_q     <= '0;
      dirty_q   <= 1'b0;
      shared_q  <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      prot_q    <= prot_d;
      target_q  <= target_d;
      ac_done_q <= ac_done_d;
      cr_done_q <= cr_done_d;
      dt_q      <= dt_d;
      fwd_q     <= fwd_d;
      cnt_q     <= cnt_d;
      dirty_q   <= dirty_d;
      shared_q  <= shared_d;
      err_q     <= err_d;
      data_q    <= data_d;
    end
  end

  assign ac_addr_o    = addr_q;
  assign ac_snoop_o   = snoop_q;
  assign ac_prot_o    = prot_q;
  assign res_data_o   = data_q;
  assign res_dirty_o  = dirty_q;
  assign res_shared_o = shared_q;
  assign res_err_o    = err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ccu_snoop_dispatch.sv
// Bench for ccu_snoop_dispatch: behavioural snooped-master model with a
// scoreboard of expected forwarded beats and merged results.
module tb_ccu_snoop_dispatch;

  localparam int unsigned NP    = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 64;
  localparam int unsigned LW    = 512;
  localparam int unsigned IW    = 2;
  localparam int unsigned BEATS = LW / DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic             req_valid_i, req_ready_o;
  logic [AW-1:0]    req_addr_i;
  logic [3:0]       req_snoop_i;
  logic [2:0]       req_prot_i;
  logic [IW-1:0]    req_init_i;
  logic [NP-1:0]    req_mask_i;
  logic [NP-1:0]    ac_valid_o, ac_ready_i;
  logic [AW-1:0]    ac_addr_o;
  logic [3:0]       ac_snoop_o;
  logic [2:0]       ac_prot_o;
  logic [NP-1:0]    cr_valid_i, cr_ready_o;
  logic [NP*5-1:0]  cr_resp_i;
  logic [NP-1:0]    cd_valid_i, cd_ready_o, cd_last_i;
  logic [NP*DW-1:0] cd_data_i;
  logic             d_valid_o, d_ready_i, d_last_o;
  logic [DW-1:0]    d_data_o;
  logic             res_valid_o, res_ready_i;
  logic             res_data_o, res_dirty_o, res_shared_o, res_err_o, busy_o;

  ccu_snoop_dispatch #(
    .NoPorts  (NP),
    .AddrWidth(AW),
    .DataWidth(DW),
    .LineWidth(LW),
    .IdxWidth (IW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_snoop_i(req_snoop_i), .req_prot_i(req_prot_i), .req_init_i(req_init_i),
    .req_mask_i(req_mask_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
    .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
    .cd_last_i(cd_last_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o), .d_last_o(d_last_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_dirty_o(res_dirty_o), .res_shared_o(res_shared_o), .res_err_o(res_err_o),
    .busy_o(busy_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW:0] exp_beats[$];   // {last, data}
  logic [3:0]  exp_res[$];     // {data, dirty, shared, err}

  logic [4:0]  cfg_cr[NP];
  int          cfg_dly[NP];
  bit          cfg_dtog;
  bit          cfg_badlast;
  int          cfg_rst_beat;

  logic [NP-1:0] obs_ac;
  int            obs_beats, obs_lat, obs_dup, obs_badcdr;
  int            obs_sent[NP];
  bit            obs_done, obs_abort;

  task automatic idle_inputs();
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_snoop_i = '0;
    req_prot_i  = '0;
    req_init_i  = '0;
    req_mask_i  = '0;
    ac_ready_i  = '0;
    cr_valid_i  = '0;
    cr_resp_i   = '0;
    cd_valid_i  = '0;
    cd_data_i   = '0;
    cd_last_i   = '0;
    d_ready_i   = 1'b0;
    res_ready_i = 1'b0;
  endtask

  task automatic cfg_clear();
    for (int p = 0; p < NP; p++) begin
      cfg_cr[p]  = '0;
      cfg_dly[p] = 0;
    end
    cfg_dtog     = 1'b0;
    cfg_badlast  = 1'b0;
    cfg_rst_beat = 0;
  endtask

  // Runs one request through the master model, scoring every d beat and the result.
  task automatic run_txn(input logic [IW-1:0] init, input logic [NP-1:0] mask,
                         input logic [AW-1:0] addr);
    logic [NP-1:0] tgt, dt, ac_seen, cr_sent;
    logic          pd, is, er;
    logic [DW:0]   b;
    logic [3:0]    r;
    int            fwd, acc_cyc;
    bit            acc;

    tgt = mask & ~(NP'(1) << init);
    dt  = '0;
    pd  = 1'b0; is = 1'b0; er = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (tgt[p]) begin
        pd    = pd | cfg_cr[p][2];
        is    = is | cfg_cr[p][3];
        er    = er | cfg_cr[p][1];
        dt[p] = cfg_cr[p][0] & ~cfg_cr[p][1];
      end
    end
    fwd = -1;
    for (int p = NP - 1; p >= 0; p--) if (dt[p]) fwd = p;
    if (fwd >= 0) begin
      for (int k = 0; k < BEATS; k++) exp_beats.push_back({k == BEATS - 1, DW'(fwd * 8 + k)});
      er = er | cfg_badlast;
    end
    exp_res.push_back({fwd >= 0, pd, is, er});

    ac_seen = '0; cr_sent = '0; obs_ac = '0;
    obs_beats = 0; obs_lat = -1; obs_dup = 0; obs_badcdr = 0;
    obs_done = 1'b0; obs_abort = 1'b0;
    for (int p = 0; p < NP; p++) obs_sent[p] = 0;
    acc = 1'b0; acc_cyc = 0;

    for (int cyc = 0; cyc < 400 && !obs_done && !obs_abort; cyc++) begin
      @(negedge clk);
      req_valid_i = !acc;
      req_addr_i  = addr;
      req_snoop_i = 4'h7;
      req_prot_i  = 3'b010;
      req_init_i  = init;
      req_mask_i  = mask;
      for (int p = 0; p < NP; p++) begin
        ac_ready_i[p]      = acc && (cyc - acc_cyc >= 1 + cfg_dly[p]);
        cr_valid_i[p]      = ac_seen[p] && !cr_sent[p];
        cr_resp_i[p*5 +: 5] = cfg_cr[p];
        cd_valid_i[p]      = cr_sent[p] && dt[p] && (obs_sent[p] < BEATS);
        cd_data_i[p*DW +: DW] = DW'(p * 8 + obs_sent[p]);
        cd_last_i[p]       = (obs_sent[p] == BEATS - 1) ^ (cfg_badlast && obs_sent[p] == 0);
      end
      d_ready_i   = cfg_dtog ? (cyc % 2 == 1) : 1'b1;
      res_ready_i = 1'b1;
      #1;
      if (!acc && req_ready_o) begin
        acc     = 1'b1;
        acc_cyc = cyc;
      end
      for (int p = 0; p < NP; p++) begin
        if (ac_valid_o[p] && (!tgt[p] || ac_seen[p])) obs_dup++;
        if (ac_valid_o[p] && ac_ready_i[p]) begin
          ac_seen[p] = 1'b1;
          obs_ac[p]  = 1'b1;
        end
        if (cr_valid_i[p] && cr_ready_o[p]) cr_sent[p] = 1'b1;
        if (cd_valid_i[p] && cd_ready_o[p]) obs_sent[p]++;
        if (cd_ready_o[p] && !dt[p]) obs_badcdr++;
      end
      if (ac_valid_o != '0) begin
        checks++;
        if (ac_addr_o !== addr || ac_snoop_o !== 4'h7 || ac_prot_o !== 3'b010) begin
          failures++;
          $display("FAIL ac_fields: got addr=%h snoop=%h prot=%h expected addr=%h snoop=7 prot=2",
                   ac_addr_o, ac_snoop_o, ac_prot_o, addr);
        end
      end
      if (d_valid_o && d_ready_i) begin
        obs_beats++;
        checks++;
        if (exp_beats.size() == 0) begin
          failures++;
          $display("FAIL d_beat: got last=%b data=%h expected no beat", d_last_o, d_data_o);
        end else begin
          b = exp_beats.pop_front();
          if ({d_last_o, d_data_o} !== b) begin
            failures++;
            $display("FAIL d_beat: got last=%b data=%h expected last=%b data=%h",
                     d_last_o, d_data_o, b[DW], b[DW-1:0]);
          end
        end
        if (obs_beats == cfg_rst_beat) obs_abort = 1'b1;
      end
      if (res_valid_o && !obs_abort) begin
        obs_lat = cyc - acc_cyc;
        obs_done = 1'b1;
        checks++;
        if (exp_beats.size() != 0) begin
          failures++;
          $display("FAIL d_order: result with %0d beats outstanding, expected 0", exp_beats.size());
        end
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL res_flags: got unexpected result");
        end else begin
          r = exp_res.pop_front();
          if ({res_data_o, res_dirty_o, res_shared_o, res_err_o} !== r) begin
            failures++;
            $display("FAIL res_flags: got data/dirty/shared/err=%b%b%b%b expected %b",
                     res_data_o, res_dirty_o, res_shared_o, res_err_o, r);
          end
        end
      end
    end

    if (obs_abort) begin
      @(negedge clk);
      rst_i = 1'b1;
    end else if (!obs_done) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout: got no result within 400 cycles, expected a result");
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if ({ac_valid_o, cr_ready_o, cd_ready_o, d_valid_o, res_valid_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ac_v=%b cr_r=%b cd_r=%b d_v=%b res_v=%b busy=%b expected all 0",
               ac_valid_o, cr_ready_o, cd_ready_o, d_valid_o, res_valid_o, busy_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready_o);
    end
  endtask

  task automatic test_no_data();
    cfg_clear();
    run_txn(2'd1, 4'b1111, 64'h0000_1000_0000_0040);
    checks++;
    if (obs_ac !== 4'b1101) begin
      failures++;
      $display("FAIL no_data_ac_ports: got %b expected 1101", obs_ac);
    end
    checks++;
    if (obs_beats != 0 || obs_dup != 0) begin
      failures++;
      $display("FAIL no_data_beats: got beats=%0d dup_ac=%0d expected 0 and 0", obs_beats, obs_dup);
    end
  endtask

  task automatic test_forward();
    cfg_clear();
    cfg_cr[2] = 5'b00101;
    cfg_cr[3] = 5'b01001;
    run_txn(2'd1, 4'b1111, 64'hdead_beef_0000_0080);
    checks++;
    if (obs_beats != BEATS) begin
      failures++;
      $display("FAIL fwd_beats: got %0d expected %0d", obs_beats, BEATS);
    end
    checks++;
    if (obs_sent[3] != BEATS || obs_badcdr != 0) begin
      failures++;
      $display("FAIL fwd_drain: got port3 beats=%0d stray_cd_ready=%0d expected %0d and 0",
               obs_sent[3], obs_badcdr, BEATS);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL fwd_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    cfg_clear();
    cfg_cr[2]  = 5'b00101;
    cfg_cr[3]  = 5'b00001;
    cfg_dly[3] = 5;
    cfg_dtog   = 1'b1;
    for (int t = 0; t < 2; t++) begin
      run_txn(2'd1, 4'b1111, AW'(64'h100 + t * 64'h40));
      checks++;
      if (obs_dup != 0 || obs_ac !== 4'b1101) begin
        failures++;
        $display("FAIL b2b_ac: run %0d got dup=%0d ports=%b expected 0 and 1101", t, obs_dup, obs_ac);
      end
      checks++;
      if (obs_beats != BEATS || obs_sent[3] != BEATS) begin
        failures++;
        $display("FAIL b2b_beats: run %0d got fwd=%0d drained=%0d expected %0d", t, obs_beats,
                 obs_sent[3], BEATS);
      end
    end
  endtask

  task automatic test_self_only();
    cfg_clear();
    cfg_cr[2] = 5'b00101;
    run_txn(2'd2, 4'b0100, 64'h2000);
    checks++;
    if (obs_lat != 1) begin
      failures++;
      $display("FAIL self_latency: got %0d cycles expected 1", obs_lat);
    end
    checks++;
    if (obs_ac !== 4'b0000 || obs_beats != 0) begin
      failures++;
      $display("FAIL self_activity: got ac=%b beats=%0d expected 0000 and 0", obs_ac, obs_beats);
    end
  endtask

  task automatic test_error();
    cfg_clear();
    cfg_cr[0] = 5'b00011;
    cfg_cr[2] = 5'b00001;
    run_txn(2'd1, 4'b1111, 64'h3000);
    checks++;
    if (obs_badcdr != 0 || obs_sent[0] != 0) begin
      failures++;
      $display("FAIL err_port0_cd: got stray_cd_ready=%0d port0 beats=%0d expected 0 and 0",
               obs_badcdr, obs_sent[0]);
    end
    checks++;
    if (obs_sent[2] != BEATS) begin
      failures++;
      $display("FAIL err_fwd_port2: got %0d beats expected %0d", obs_sent[2], BEATS);
    end
  endtask

  task automatic test_last_mismatch();
    cfg_clear();
    cfg_cr[3]   = 5'b00001;
    cfg_badlast = 1'b1;
    run_txn(2'd0, 4'b1001, 64'h4000);
    checks++;
    if (obs_beats != BEATS) begin
      failures++;
      $display("FAIL last_mm_beats: got %0d expected %0d", obs_beats, BEATS);
    end
  endtask

  task automatic test_reset_mid();
    cfg_clear();
    cfg_cr[2]    = 5'b00001;
    cfg_rst_beat = 3;
    run_txn(2'd1, 4'b0101, 64'h5000);
    checks++;
    if (!obs_abort) begin
      failures++;
      $display("FAIL rst_mid_reach: got beats=%0d expected to reach beat 3", obs_beats);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({ac_valid_o, d_valid_o, res_valid_o, cd_ready_o, cr_ready_o, busy_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got ac_v=%b d_v=%b res_v=%b cd_r=%b cr_r=%b busy=%b expected 0",
               ac_valid_o, d_valid_o, res_valid_o, cd_ready_o, cr_ready_o, busy_o);
    end
    exp_beats.delete();
    exp_res.delete();
    cfg_rst_beat = 0;
    run_txn(2'd1, 4'b0101, 64'h5040);
    checks++;
    if (obs_beats != BEATS) begin
      failures++;
      $display("FAIL rst_mid_recover: got %0d beats expected %0d", obs_beats, BEATS);
    end
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_forward();
    test_back_to_back();
    test_self_only();
    test_error();
    test_last_mismatch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
